reg_file_1wp_v: RTL and testbench

Register file whose whole contents are driven out as one packed vector, updated through a single addressed write port with a valid/ready handshake. A sequential clear engine zeroes the file one entry per cycle. Per-entry dirty flags let a consumer snapshot only changed entries. Its packed output uses the same layout as the parallel register input of the one-read-port register files, so it is the writer-side counterpart feeding those blocks.

---
 rtl/reg_file_1wp_v.sv | 122 ++++++++++++
 tb/tb_reg_file_1wp_v.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_1wp_v.sv
// Register file with one addressed write port and a sequential clear engine.
// Ports: clock/reset, wr_valid/wr_ready/wr_addr/wr_data, clr_req/busy, snap, r_out, dirty.
module reg_file_1wp_v #(
  parameter int NREGS = 2,
  parameter int WIDTH = 16,
  parameter int AW    = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   clr_req,
  output logic                   busy,
  input  logic                   snap,
  output logic [NREGS*WIDTH-1:0] r_out,
  output logic [NREGS-1:0]       dirty
);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  state_t           state;
  state_t           state_nx;
  logic [AW-1:0]    cnt;
  logic [AW-1:0]    cnt_nx;
  logic             clr_step;
  logic             wr_fire;
  logic             in_range;
  logic [NREGS-1:0] set_vec;
  logic [WIDTH-1:0] regs [NREGS];

  // Out-of-range writes still handshake but touch nothing.
  assign in_range = (32'(wr_addr) < NREGS);
  assign wr_fire  = wr_valid & wr_ready & in_range;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    wr_ready = 1'b0;
    busy     = 1'b0;
    clr_step = 1'b0;
    case (state)
      IDLE: begin
        wr_ready = 1'b1;
        if (clr_req) begin
          state_nx = CLEAR;
          cnt_nx   = '0;
        end
      end
      CLEAR: begin
        busy     = 1'b1;
        clr_step = 1'b1;
        cnt_nx   = cnt + 1'b1;
        if (cnt == LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_comb begin
    set_vec = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (clr_step && cnt == AW'(i))
        set_vec[i] = 1'b1;
      if (wr_fire && wr_addr == AW'(i))
        set_vec[i] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Clear steps and writes never coincide: writes only fire in IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (clr_step && cnt == AW'(i))
          regs[i] <= '0;
        else if (wr_fire && wr_addr == AW'(i))
          regs[i] <= wr_data;
      end
    end
  end

  // A set in the same cycle as snap wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      dirty <= '0;
    else
      dirty <= (snap ? '0 : dirty) | set_vec;
  end

  // Reg 0 occupies the MSBs.
  always_comb begin
    r_out = '0;
    for (int i = 0; i < NREGS; i++)
      r_out[WIDTH*(NREGS-1-i) +: WIDTH] = regs[i];
  end

endmodule

// File: tb/tb_reg_file_1wp_v.sv
// Directed bench for reg_file_1wp_v.
// Drives inputs 1ns after rising edges and checks outputs before the next edge.
module tb_reg_file_1wp_v;

  logic        clock = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [0:0]  wr_addr;
  logic [15:0] wr_data;
  logic        clr_req;
  logic        busy;
  logic        snap;
  logic [31:0] r_out;
  logic [1:0]  dirty;

  int checks = 0;
  int passed = 0;

  always #5 clock = ~clock;

  reg_file_1wp_v #(.NREGS(2), .WIDTH(16), .AW(1)) dut (
    .clock    (clock),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .clr_req  (clr_req),
    .busy     (busy),
    .snap     (snap),
    .r_out    (r_out),
    .dirty    (dirty)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    clr_req  = 1'b0;
    snap     = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    checks++;
    if (r_out !== 32'h0000_0000)
      $display("FAIL reset_r_out got %h want %h", r_out, 32'h0);
    else passed++;
    checks++;
    if (dirty !== 2'b00)
      $display("FAIL reset_dirty got %b want 00", dirty);
    else passed++;
    checks++;
    if ({wr_ready, busy} !== 2'b10)
      $display("FAIL reset_rdy_busy got %b want 10", {wr_ready, busy});
    else passed++;
  endtask

  task automatic test_write();
    wr_valid = 1'b1;
    wr_addr  = 1'b0;
    wr_data  = 16'hBEEF;
    step();
    checks++;
    if (r_out !== 32'hBEEF_0000 || dirty !== 2'b01)
      $display("FAIL write0 got %h/%b want beef0000/01", r_out, dirty);
    else passed++;
    wr_addr = 1'b1;
    wr_data = 16'h1234;
    step();
    wr_valid = 1'b0;
    checks++;
    if (r_out !== 32'hBEEF_1234 || dirty !== 2'b11)
      $display("FAIL write1 got %h/%b want beef1234/11", r_out, dirty);
    else passed++;
    snap = 1'b1;
    step();
    snap = 1'b0;
    checks++;
    if (r_out !== 32'hBEEF_1234 || dirty !== 2'b00)
      $display("FAIL snap got %h/%b want beef1234/00", r_out, dirty);
    else passed++;
  endtask

  task automatic test_set_wins();
    wr_valid = 1'b1;
    wr_addr  = 1'b0;
    wr_data  = 16'hBEEF;
    step();
    checks++;
    if (dirty !== 2'b01)
      $display("FAIL pre_snap_dirty got %b want 01", dirty);
    else passed++;
    wr_addr = 1'b1;
    wr_data = 16'h5555;
    snap    = 1'b1;
    step();
    checks++;
    if (r_out !== 32'hBEEF_5555 || dirty !== 2'b10)
      $display("FAIL set_wins got %h/%b want beef5555/10", r_out, dirty);
    else passed++;
    wr_data = 16'h1234;
    step();
    snap     = 1'b0;
    wr_valid = 1'b0;
    checks++;
    if (r_out !== 32'hBEEF_1234 || dirty !== 2'b10)
      $display("FAIL restore got %h/%b want beef1234/10", r_out, dirty);
    else passed++;
  endtask

  task automatic test_clear();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    checks++;
    if ({busy, wr_ready} !== 2'b10 || r_out !== 32'hBEEF_1234)
      $display("FAIL clr_c1 got %b/%h want 10/beef1234",
               {busy, wr_ready}, r_out);
    else passed++;
    step();
    checks++;
    if ({busy, wr_ready} !== 2'b10 || r_out !== 32'h0000_1234)
      $display("FAIL clr_c2 got %b/%h want 10/00001234",
               {busy, wr_ready}, r_out);
    else passed++;
    step();
    checks++;
    if ({busy, wr_ready} !== 2'b01 || r_out !== 32'h0 || dirty !== 2'b11)
      $display("FAIL clr_done got %b/%h/%b want 01/00000000/11",
               {busy, wr_ready}, r_out, dirty);
    else passed++;
  endtask

  task automatic test_hold_during_clear();
    clr_req = 1'b1;
    step();
    wr_valid = 1'b1;
    wr_addr  = 1'b1;
    wr_data  = 16'hAAAA;
    step();
    clr_req = 1'b0;
    checks++;
    if ({busy, wr_ready} !== 2'b10 || r_out !== 32'h0)
      $display("FAIL hold_c2 got %b/%h want 10/00000000",
               {busy, wr_ready}, r_out);
    else passed++;
    step();
    checks++;
    if ({busy, wr_ready} !== 2'b01 || r_out !== 32'h0)
      $display("FAIL hold_end got %b/%h want 01/00000000",
               {busy, wr_ready}, r_out);
    else passed++;
    step();
    wr_valid = 1'b0;
    checks++;
    if (r_out !== 32'h0000_AAAA || busy !== 1'b0)
      $display("FAIL hold_land got %h/%b want 0000aaaa/0", r_out, busy);
    else passed++;
    step();
    checks++;
    if (busy !== 1'b0 || r_out !== 32'h0000_AAAA)
      $display("FAIL clr_ignored got %b/%h want 0/0000aaaa", busy, r_out);
    else passed++;
  endtask

  task automatic test_write_with_clear();
    wr_valid = 1'b1;
    wr_addr  = 1'b0;
    wr_data  = 16'h1111;
    clr_req  = 1'b1;
    step();
    wr_valid = 1'b0;
    clr_req  = 1'b0;
    checks++;
    if (r_out !== 32'h1111_AAAA || busy !== 1'b1)
      $display("FAIL wc_land got %h/%b want 1111aaaa/1", r_out, busy);
    else passed++;
    step();
    checks++;
    if (r_out !== 32'h0000_AAAA)
      $display("FAIL wc_step1 got %h want 0000aaaa", r_out);
    else passed++;
    step();
    checks++;
    if (r_out !== 32'h0 || busy !== 1'b0)
      $display("FAIL wc_step2 got %h/%b want 00000000/0", r_out, busy);
    else passed++;
  endtask

  task automatic test_reset_mid_clear();
    wr_valid = 1'b1;
    wr_addr  = 1'b0;
    wr_data  = 16'hFFFF;
    step();
    wr_addr = 1'b1;
    step();
    wr_valid = 1'b0;
    checks++;
    if (r_out !== 32'hFFFF_FFFF)
      $display("FAIL fill got %h want ffffffff", r_out);
    else passed++;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    reset   = 1'b1;
    #1;
    checks++;
    if (r_out !== 32'h0 || dirty !== 2'b00 || {busy, wr_ready} !== 2'b01)
      $display("FAIL async_rst got %h/%b/%b want 00000000/00/01",
               r_out, dirty, {busy, wr_ready});
    else passed++;
    step();
    reset = 1'b0;
    step();
    checks++;
    if ({busy, wr_ready} !== 2'b01 || r_out !== 32'h0)
      $display("FAIL post_rst got %b/%h want 01/00000000",
               {busy, wr_ready}, r_out);
    else passed++;
    wr_valid = 1'b1;
    wr_addr  = 1'b1;
    wr_data  = 16'h0042;
    step();
    wr_valid = 1'b0;
    checks++;
    if (r_out !== 32'h0000_0042 || dirty !== 2'b10)
      $display("FAIL post_rst_wr got %h/%b want 00000042/10", r_out, dirty);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_set_wins();
    test_clear();
    test_hold_during_clear();
    test_write_with_clear();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
